// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control FSM: FETCH/DECODE/EXEC/MEM/WB/TRAP over one shared memory port.
// Optional retire counter on o_instret enabled by defining CTRL_INSTRET_EN.
module multicycle_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [6:0]       i_opcode,
    input  logic             i_branch_taken,
    input  logic             i_mem_ready,
    output logic             o_mem_req,
    output logic             o_mem_we,
    output logic             o_addr_sel,
    output logic             o_ir_we,
    output logic             o_alu_src_imm,
    output logic             o_alu_src_pc,
    output logic             o_rf_we,
    output logic [1:0]       o_wb_sel,
    output logic             o_pc_we,
    output logic [1:0]       o_pc_sel,
    output logic             o_trap,
    output logic [WIDTH-1:0] o_instret
);

    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef enum logic [2:0] {
        FETCH, DECODE, EXEC, MEM, WB, TRAP
    } state_t;

    state_t     state, state_next;
    logic [6:0] opcode_q;

    function automatic logic is_legal(input logic [6:0] op);
        case (op)
            OP_REG, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH,
            OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: is_legal = 1'b1;
            default:                           is_legal = 1'b0;
        endcase
    endfunction

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state    <= FETCH;
            opcode_q <= '0;
        end else begin
            state <= state_next;
            if (state == DECODE)
                opcode_q <= i_opcode;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            FETCH:  if (i_mem_ready) state_next = DECODE;
            DECODE: state_next = is_legal(i_opcode) ? EXEC : TRAP;
            EXEC: begin
                if (opcode_q == OP_BRANCH)
                    state_next = FETCH;
                else if (opcode_q == OP_LOAD || opcode_q == OP_STORE)
                    state_next = MEM;
                else
                    state_next = WB;
            end
            MEM:    if (i_mem_ready) state_next = (opcode_q == OP_LOAD) ? WB : FETCH;
            WB:     state_next = FETCH;
            TRAP:   state_next = TRAP;
            default: state_next = FETCH;
        endcase
    end

    // NOTE: every output gets a default first, so no path through the case can infer a latch.
    always_comb begin
        o_mem_req     = 1'b0;
        o_mem_we      = 1'b0;
        o_addr_sel    = 1'b0;
        o_ir_we       = 1'b0;
        o_alu_src_imm = 1'b0;
        o_alu_src_pc  = 1'b0;
        o_rf_we       = 1'b0;
        o_wb_sel      = 2'd0;
        o_pc_we       = 1'b0;
        o_pc_sel      = 2'd0;
        o_trap        = 1'b0;
        // Gating by reset drops a pending request in the very cycle reset is seen.
        if (i_rst_n) begin
            case (state)
                FETCH: begin
                    o_mem_req = 1'b1;
                    o_ir_we   = i_mem_ready;
                end
                EXEC: begin
                    o_alu_src_imm = (opcode_q == OP_IMM)   || (opcode_q == OP_LOAD) ||
                                    (opcode_q == OP_STORE) || (opcode_q == OP_JALR);
                    o_alu_src_pc  = (opcode_q == OP_AUIPC);
                    if (opcode_q == OP_BRANCH) begin
                        o_pc_we  = 1'b1;
                        o_pc_sel = i_branch_taken ? 2'd1 : 2'd0;
                    end
                end
                MEM: begin
                    o_mem_req  = 1'b1;
                    o_addr_sel = 1'b1;
                    o_mem_we   = (opcode_q == OP_STORE);
                    o_pc_we    = (opcode_q == OP_STORE) && i_mem_ready;
                end
                WB: begin
                    o_rf_we = 1'b1;
                    o_pc_we = 1'b1;
                    case (opcode_q)
                        OP_LOAD:          o_wb_sel = 2'd1;
                        OP_JAL, OP_JALR:  o_wb_sel = 2'd2;
                        OP_LUI:           o_wb_sel = 2'd3;
                        default:          o_wb_sel = 2'd0;
                    endcase
                    case (opcode_q)
                        OP_JAL:  o_pc_sel = 2'd1;
                        OP_JALR: o_pc_sel = 2'd2;
                        default: o_pc_sel = 2'd0;
                    endcase
                end
                TRAP:    o_trap = 1'b1;
                default: ;
            endcase
        end
    end

`ifdef CTRL_INSTRET_EN
    logic [WIDTH-1:0] instret_q;
    logic             retire;

    assign retire = (state == WB) ||
                    (state == EXEC && opcode_q == OP_BRANCH) ||
                    (state == MEM && opcode_q == OP_STORE && i_mem_ready);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n)
            instret_q <= '0;
        else if (retire)
            instret_q <= instret_q + 1'b1;
    end

    assign o_instret = instret_q;
`else
    assign o_instret = '0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed self-checking bench for multicycle_ctrl; expected control vectors are hand-computed.
// Retire-count expectations follow CTRL_INSTRET_EN when defined, otherwise o_instret must stay 0.
module tb_multicycle_ctrl;

    localparam int WIDTH = 32;

`ifdef CTRL_INSTRET_EN
    localparam bit INSTRET_ON = 1'b1;
`else
    localparam bit INSTRET_ON = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic [6:0]       opcode;
    logic             branch_taken;
    logic             mem_ready;
    logic             mem_req, mem_we, addr_sel, ir_we, alu_src_imm, alu_src_pc;
    logic             rf_we, pc_we, trap;
    logic [1:0]       wb_sel, pc_sel;
    logic [WIDTH-1:0] instret;

    int n_checks = 0;
    int n_errors = 0;

    multicycle_ctrl #(.WIDTH(WIDTH)) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_opcode      (opcode),
        .i_branch_taken(branch_taken),
        .i_mem_ready   (mem_ready),
        .o_mem_req     (mem_req),
        .o_mem_we      (mem_we),
        .o_addr_sel    (addr_sel),
        .o_ir_we       (ir_we),
        .o_alu_src_imm (alu_src_imm),
        .o_alu_src_pc  (alu_src_pc),
        .o_rf_we       (rf_we),
        .o_wb_sel      (wb_sel),
        .o_pc_we       (pc_we),
        .o_pc_sel      (pc_sel),
        .o_trap        (trap),
        .o_instret     (instret)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // Packed view: {req, we, addr, ir, imm, pc, rf, wb_sel[1:0], pc_we, pc_sel[1:0], trap}
    logic [13:0] outs;
    assign outs = {mem_req, mem_we, addr_sel, ir_we, alu_src_imm, alu_src_pc,
                   rf_we, wb_sel, pc_we, pc_sel, trap};

    function automatic logic [13:0] v(input logic req, we, addr, ir, imm, pc, rf,
                                      input logic [1:0] wb, input logic pcwe,
                                      input logic [1:0] pcs, input logic trp);
        v = {req, we, addr, ir, imm, pc, rf, wb, pcwe, pcs, trp};
    endfunction

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Settle inputs, compare outputs of the current cycle, then advance one clock.
    task automatic step(input string tag, input logic [13:0] expected);
        #2;
        check(tag, {18'd0, outs}, {18'd0, expected});
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_instret(input string tag, input int n);
        #2;
        check(tag, instret, INSTRET_ON ? n : 0);
    endtask

    localparam logic [13:0] ZERO = 14'd0;

    initial begin
        rst_n = 1'b0; opcode = 7'b0010011; branch_taken = 1'b0; mem_ready = 1'b1;
        @(posedge clk); #1;
        step("reset_outputs", ZERO);
        check_instret("reset_instret", 0);
        rst_n = 1'b1;

        // ADDI: 4 cycles
        step("addi_fetch",  v(1,0,0,1,0,0,0,2'd0,0,2'd0,0));
        step("addi_decode", ZERO);
        step("addi_exec",   v(0,0,0,0,1,0,0,2'd0,0,2'd0,0));
        step("addi_wb",     v(0,0,0,0,0,0,1,2'd0,1,2'd0,0));
        check_instret("instret_addi", 1);

        // LOAD with 3 wait cycles in MEM: 8 cycles
        opcode = 7'b0000011;
        step("load_fetch",  v(1,0,0,1,0,0,0,2'd0,0,2'd0,0));
        step("load_decode", ZERO);
        step("load_exec",   v(0,0,0,0,1,0,0,2'd0,0,2'd0,0));
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++)
            step("load_mem_wait", v(1,0,1,0,0,0,0,2'd0,0,2'd0,0));
        mem_ready = 1'b1;
        step("load_mem_ready", v(1,0,1,0,0,0,0,2'd0,0,2'd0,0));
        step("load_wb",        v(0,0,0,0,0,0,1,2'd1,1,2'd0,0));
        check_instret("instret_load", 2);

        // BRANCH taken then not taken: 3 cycles each
        opcode = 7'b1100011; branch_taken = 1'b1;
        step("br1_fetch",  v(1,0,0,1,0,0,0,2'd0,0,2'd0,0));
        step("br1_decode", ZERO);
        step("br1_exec",   v(0,0,0,0,0,0,0,2'd0,1,2'd1,0));
        branch_taken = 1'b0;
        step("br0_fetch",  v(1,0,0,1,0,0,0,2'd0,0,2'd0,0));
        step("br0_decode", ZERO);
        step("br0_exec",   v(0,0,0,0,0,0,0,2'd0,1,2'd0,0));
        check_instret("instret_branch", 4);

        // JALR
        opcode = 7'b1100111;
        step("jalr_fetch",  v(1,0,0,1,0,0,0,2'd0,0,2'd0,0));
        step("jalr_decode", ZERO);
        step("jalr_exec",   v(0,0,0,0,1,0,0,2'd0,0,2'd0,0));
        step("jalr_wb",     v(0,0,0,0,0,0,1,2'd2,1,2'd2,0));

        // STORE: 4 cycles, no rf_we
        opcode = 7'b0100011;
        step("store_fetch",  v(1,0,0,1,0,0,0,2'd0,0,2'd0,0));
        step("store_decode", ZERO);
        step("store_exec",   v(0,0,0,0,1,0,0,2'd0,0,2'd0,0));
        step("store_mem",    v(1,1,1,0,0,0,0,2'd0,1,2'd0,0));
        check_instret("instret_store", 6);

        // JAL with one fetch wait cycle: ir_we only on the ready cycle
        opcode = 7'b1101111; mem_ready = 1'b0;
        step("jal_fetch_wait", v(1,0,0,0,0,0,0,2'd0,0,2'd0,0));
        mem_ready = 1'b1;
        step("jal_fetch",  v(1,0,0,1,0,0,0,2'd0,0,2'd0,0));
        step("jal_decode", ZERO);
        step("jal_exec",   ZERO);
        step("jal_wb",     v(0,0,0,0,0,0,1,2'd2,1,2'd1,0));

        // AUIPC and LUI
        opcode = 7'b0010111;
        step("auipc_fetch",  v(1,0,0,1,0,0,0,2'd0,0,2'd0,0));
        step("auipc_decode", ZERO);
        step("auipc_exec",   v(0,0,0,0,0,1,0,2'd0,0,2'd0,0));
        step("auipc_wb",     v(0,0,0,0,0,0,1,2'd0,1,2'd0,0));
        opcode = 7'b0110111;
        step("lui_fetch",  v(1,0,0,1,0,0,0,2'd0,0,2'd0,0));
        step("lui_decode", ZERO);
        step("lui_exec",   ZERO);
        step("lui_wb",     v(0,0,0,0,0,0,1,2'd3,1,2'd0,0));
        check_instret("instret_nine", 9);

        // Reset in the middle of a STORE's MEM wait
        opcode = 7'b0100011;
        step("st2_fetch",  v(1,0,0,1,0,0,0,2'd0,0,2'd0,0));
        step("st2_decode", ZERO);
        step("st2_exec",   v(0,0,0,0,1,0,0,2'd0,0,2'd0,0));
        mem_ready = 1'b0;
        step("st2_mem_wait", v(1,1,1,0,0,0,0,2'd0,0,2'd0,0));
        rst_n = 1'b0; mem_ready = 1'b1;
        step("st2_reset_cycle", ZERO);
        rst_n = 1'b1;
        check_instret("instret_after_reset", 0);

        // Five back-to-back ADDIs
        opcode = 7'b0010011;
        step("post_reset_fetch", v(1,0,0,1,0,0,0,2'd0,0,2'd0,0));
        for (int i = 0; i < 19; i++)
            tick();
        check_instret("instret_five_addi", 5);

        // Illegal opcode: TRAP is absorbing until reset
        opcode = 7'b0000000;
        step("ill_fetch",  v(1,0,0,1,0,0,0,2'd0,0,2'd0,0));
        step("ill_decode", ZERO);
        for (int i = 0; i < 12; i++)
            step("trap_hold", v(0,0,0,0,0,0,0,2'd0,0,2'd0,1));
        check_instret("instret_trap", 5);
        rst_n = 1'b0;
        step("trap_reset_cycle", ZERO);
        rst_n = 1'b1; opcode = 7'b0010011;
        step("trap_exit_fetch", v(1,0,0,1,0,0,0,2'd0,0,2'd0,0));
        check_instret("instret_final", 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Multi-cycle control FSM for the RV32I core. Sequences fetch, decode, execute, memory and writeback over a single shared instruction/data memory port. Consumes the opcode field produced by the instruction decoder and drives the write enables and mux selects for the PC, IR, ALU, register file and memory. One instruction is in flight at a time; there is no pipelining.

Parameters:
- WIDTH, 32, datapath width; sets the optional retire counter width.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  synchronous active-low reset.
- i_opcode  in  7  opcode field from the decoder, sourced from the IR.
- i_branch_taken  in  1  branch comparator result, valid in EXEC.
- i_mem_ready  in  1  memory completes the current request this cycle.
- o_mem_req  out  1  memory request, held until ready.
- o_mem_we  out  1  1 = store, 0 = read.
- o_addr_sel  out  1  0 = PC, 1 = ALU result as memory address.
- o_ir_we  out  1  latch instruction register.
- o_alu_src_imm  out  1  ALU operand B: 0 = rs2, 1 = immediate.
- o_alu_src_pc  out  1  ALU operand A: 0 = rs1, 1 = PC (AUIPC).
- o_rf_we  out  1  register file write.
- o_wb_sel  out  2  writeback source: 0 = ALU, 1 = mem, 2 = PC+4, 3 = imm.
- o_pc_we  out  1  PC update.
- o_pc_sel  out  2  next PC: 0 = PC+4, 1 = PC+imm, 2 = (rs1+imm)&~1.
- o_trap  out  1  illegal opcode seen; sticky.
- o_instret  out  WIDTH  retired instruction count (optional feature).

Behaviour:
- Reset is synchronous on i_clk while i_rst_n=0. All outputs are 0 and the state goes to FETCH. A reset mid-instruction aborts it with no PC, RF or memory side effects, and o_mem_req drops in the reset cycle.
- States: FETCH, DECODE, EXEC, MEM, WB, TRAP. All outputs are Moore/Mealy combinational from state, registered opcode and inputs. Unlisted outputs are 0.
- FETCH:
  - o_mem_req=1, o_addr_sel=0.
  - While i_mem_ready=0, stay in FETCH.
  - When ready, o_ir_we=1 in the same cycle and go to DECODE.
- DECODE:
  - One cycle; the opcode is registered internally.
  - Legal opcodes: 0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111, 0110111, 0010111. Any other goes to TRAP; otherwise go to EXEC.
- EXEC:
  - Drive ALU selects: src_imm=1 for OP-IMM/LOAD/STORE/JALR; src_pc=1 for AUIPC.
  - BRANCH: o_pc_we=1, o_pc_sel = i_branch_taken ? 1 : 0, then go to FETCH (3 cycles with ready on the first request).
  - LOAD/STORE go to MEM; all other opcodes go to WB.
- MEM:
  - o_mem_req=1, o_addr_sel=1, o_mem_we=1 for STORE.
  - Stay in MEM until i_mem_ready.
  - LOAD: on ready, go to WB.
  - STORE: on ready, o_pc_we=1, o_pc_sel=0, then go to FETCH.
- WB:
  - o_rf_we=1 and o_pc_we=1; go to FETCH.
  - wb_sel: OP/OP-IMM/AUIPC = 0, LOAD = 1, JAL/JALR = 2, LUI = 3.
  - pc_sel: JAL = 1, JALR = 2, otherwise 0.
- TRAP: absorbing state; o_trap=1, no requests or enables, exit only by reset.
- Minimum latency with ready on the first request cycle:
  - 3 cycles: BRANCH.
  - 4 cycles: ALU, LUI, AUIPC, JAL, JALR, STORE.
  - 5 cycles: LOAD.
- Each memory wait cycle adds 1. o_mem_req never deasserts before ready, and exactly one o_ir_we pulse occurs per fetch.

Optional Feature:
- Macro CTRL_INSTRET_EN.
- Defined: o_instret is a WIDTH-bit counter, reset to 0, +1 on each retire cycle, wrapping from all-ones to 0. Retire cycles are:
  - WB exit;
  - EXEC exit for BRANCH;
  - the MEM ready cycle for STORE.
- Not defined: o_instret is tied to 0 and no counter flops exist.

Test Plan:
- ADDI (opcode 0010011), ready always 1 -> FETCH, DECODE, EXEC, WB over 4 cycles. WB shows rf_we=1, wb_sel=0, pc_we=1, pc_sel=0; alu_src_imm=1 in EXEC.
- LOAD with ready held low for 3 cycles in MEM -> mem_req stays high with addr_sel=1 throughout. WB follows the ready cycle with wb_sel=1; 8 cycles total.
- BRANCH taken=1, then taken=0 -> pc_we pulses in EXEC with pc_sel=1 then 0. rf_we never asserts; 3 cycles each.
- JALR -> WB has wb_sel=2, pc_sel=2, rf_we=1. STORE -> mem_we=1 in MEM and no rf_we.
- Opcode 0000000 -> TRAP after DECODE, o_trap=1 for 10+ cycles with all enables 0. Then i_rst_n=0 for one cycle -> o_trap=0 and mem_req=1 on the next cycle.
- Reset asserted mid-MEM of a STORE -> mem_req, mem_we and pc_we drop in that cycle, with no pc_we pulse. With CTRL_INSTRET_EN, o_instret=0 after reset, and 5 back-to-back ADDIs -> o_instret=5.
